// File: rtl/poly_lfsr_burst_gen.sv
// poly_lfsr_burst_gen: multi-step Fibonacci LFSR word generator.
// Each output word carries STEPS consecutive LFSR states (lane i = state after
// i+1 steps). Words are emitted in bursts over a valid/ready handshake, with
// seed loading, zero-seed lock-up protection and an optional burst length.
module poly_lfsr_burst_gen #(
  parameter int                WIDTH = 16,
  parameter int                STEPS = 8,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(16'hB400),
  parameter int                LEN_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     seed_load,
  input  logic [WIDTH-1:0]         seed_value,
  input  logic                     start,
  input  logic [LEN_W-1:0]         burst_len,
  input  logic                     abort,
  output logic [STEPS*WIDTH-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     done,
  output logic [LEN_W-1:0]         word_count,
  output logic                     lockup
);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t                   fsm_reg;
  logic [WIDTH-1:0]       state_reg;
  logic [WIDTH-1:0]       state_next;
  logic [WIDTH-1:0]       adv_state;
  logic [STEPS*WIDTH-1:0] lanes_next;
  logic [STEPS*WIDTH-1:0] out_data_reg;
  logic                   out_valid_reg;
  logic                   done_reg;
  logic                   lockup_reg;
  logic [LEN_W-1:0]       word_count_reg;
  logic [LEN_W-1:0]       word_count_next;
  logic [LEN_W-1:0]       len_reg;
  logic                   accept;
  logic                   last_word;

  // One Fibonacci step: shift left, feedback is the parity of the tapped bits.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  assign accept          = out_valid_reg & out_ready;
  assign word_count_next = word_count_reg + LEN_W'(1);
  assign last_word       = (len_reg != '0) && (word_count_next == len_reg);

  // State reached after a full word (STEPS steps) from the current state.
  always_comb begin
    adv_state = state_reg;
    for (int i = 0; i < STEPS; i++) begin
      adv_state = lfsr_step(adv_state);
    end
  end

  // Next LFSR state: a seed load overrides advancement; only acceptance advances.
  always_comb begin
    state_next = state_reg;
    if (seed_load) begin
      state_next = (seed_value == '0) ? '1 : seed_value;
    end else if (accept) begin
      state_next = adv_state;
    end
  end

  // Lanes of the word that will be presented from next cycle's state.
  always_comb begin
    logic [WIDTH-1:0] s;
    s          = state_next;
    lanes_next = '0;
    for (int i = 0; i < STEPS; i++) begin
      s = lfsr_step(s);
      lanes_next[i*WIDTH +: WIDTH] = s;
    end
  end

  // Burst FSM with registered state, data, valid, done, counter and lock-up flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_reg        <= IDLE;
      state_reg      <= '1;
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      done_reg       <= 1'b0;
      lockup_reg     <= 1'b0;
      word_count_reg <= '0;
      len_reg        <= '0;
    end else begin
      state_reg    <= state_next;
      out_data_reg <= lanes_next;
      done_reg     <= 1'b0;
      if (seed_load && (seed_value == '0)) begin
        lockup_reg <= 1'b1;
      end
      case (fsm_reg)
        IDLE: begin
          out_valid_reg <= 1'b0;
          // abort beats a simultaneous start
          if (start && !abort) begin
            word_count_reg <= '0;
            len_reg        <= burst_len;
            out_valid_reg  <= 1'b1;
            fsm_reg        <= RUN;
          end
        end
        RUN: begin
          // a word taken on the same edge as abort is still counted
          if (accept) begin
            word_count_reg <= word_count_next;
          end
          if (abort) begin
            out_valid_reg <= 1'b0;
            fsm_reg       <= IDLE;
          end else if (accept && last_word) begin
            done_reg      <= 1'b1;
            out_valid_reg <= 1'b0;
            fsm_reg       <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          fsm_reg       <= IDLE;
        end
      endcase
    end
  end

  assign out_data   = out_data_reg;
  assign out_valid  = out_valid_reg;
  assign done       = done_reg;
  assign word_count = word_count_reg;
  assign lockup     = lockup_reg;

endmodule
